muldiv_controller: RTL and testbench

Multi-cycle HI/LO multiply/divide controller for the pipelined MIPS core. It sits beside the E-stage ALU and decodes the R-type mult/div/HI/LO instructions in both the D and E stages. It sequences a parametrised-latency multiply or divide, owns the HI/LO registers, and raises the D-stage stall request while an operation is in flight.

---
 rtl/muldiv_controller_pkg.sv | 25 ++
 rtl/muldiv_controller_md_decoder.sv | 21 ++
 rtl/muldiv_controller.sv | 112 +++++++++++
 tb/tb_muldiv_controller.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_controller_pkg.sv
// muldiv_controller_pkg: md-class instruction encodings, decoder flags and FSM state type
package muldiv_controller_pkg;
    localparam logic [5:0] OPCODE_RTYPE = 6'h00;
    localparam logic [5:0] FUNCT_MFHI   = 6'h10;
    localparam logic [5:0] FUNCT_MTHI   = 6'h11;
    localparam logic [5:0] FUNCT_MFLO   = 6'h12;
    localparam logic [5:0] FUNCT_MTLO   = 6'h13;
    localparam logic [5:0] FUNCT_MULT   = 6'h18;
    localparam logic [5:0] FUNCT_MULTU  = 6'h19;
    localparam logic [5:0] FUNCT_DIV    = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU   = 6'h1B;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    typedef struct packed {
        logic is_mul;
        logic is_div;
        logic is_signed;
        logic is_mfhi;
        logic is_mflo;
        logic is_mthi;
        logic is_mtlo;
        logic is_md;
    } md_dec_t;
endpackage

// File: rtl/muldiv_controller_md_decoder.sv
// md_decoder: classifies an opcode/funct pair into the HI/LO multiply-divide instruction flags
module md_decoder
    import muldiv_controller_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output md_dec_t    o_dec
);
    logic w_rtype;

    assign w_rtype         = (i_opcode == OPCODE_RTYPE);
    assign o_dec.is_mul    = w_rtype && (i_funct == FUNCT_MULT || i_funct == FUNCT_MULTU);
    assign o_dec.is_div    = w_rtype && (i_funct == FUNCT_DIV  || i_funct == FUNCT_DIVU);
    assign o_dec.is_signed = w_rtype && (i_funct == FUNCT_MULT || i_funct == FUNCT_DIV);
    assign o_dec.is_mfhi   = w_rtype && (i_funct == FUNCT_MFHI);
    assign o_dec.is_mflo   = w_rtype && (i_funct == FUNCT_MFLO);
    assign o_dec.is_mthi   = w_rtype && (i_funct == FUNCT_MTHI);
    assign o_dec.is_mtlo   = w_rtype && (i_funct == FUNCT_MTLO);
    assign o_dec.is_md     = o_dec.is_mul || o_dec.is_div || o_dec.is_mfhi || o_dec.is_mflo
                          || o_dec.is_mthi || o_dec.is_mtlo;
endmodule

// File: rtl/muldiv_controller.sv
// muldiv_controller: multi-cycle HI/LO multiply/divide sequencer with D-stage stall request
module muldiv_controller
    import muldiv_controller_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       D_Opcode,
    input  logic [5:0]       D_Funct,
    input  logic [5:0]       E_Opcode,
    input  logic [5:0]       E_Funct,
    input  logic             E_Valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Start,
    output logic             Busy,
    output logic             StallReq,
    output logic             MDRead,
    output logic [WIDTH-1:0] MDOut,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    md_dec_t            w_d_dec, w_e_dec;
    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
    logic               r_mul, r_signed, w_done;
    logic               w_neg_a, w_neg_b;
    logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_q, w_r, w_quo, w_rem;

    md_decoder u_d_dec (.i_opcode(D_Opcode), .i_funct(D_Funct), .o_dec(w_d_dec));
    md_decoder u_e_dec (.i_opcode(E_Opcode), .i_funct(E_Funct), .o_dec(w_e_dec));

    assign Start    = E_Valid && w_e_dec.is_md && (w_e_dec.is_mul || w_e_dec.is_div) && !Busy;
    // every decoder flag is zero for non-md instructions, so any set bit means md-class
    assign StallReq = (Start || Busy) && (|w_d_dec);
    assign MDRead   = w_e_dec.is_mfhi || w_e_dec.is_mflo;
    assign MDOut    = w_e_dec.is_mfhi ? r_hi : w_e_dec.is_mflo ? r_lo : '0;
    assign HI       = r_hi;
    assign LO       = r_lo;
    assign w_done   = Busy && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == S_IDLE) ? (Start ? S_RUN : S_IDLE) : (w_done ? S_IDLE : S_RUN);
    end

    always_comb begin
        Busy = (r_state == S_RUN);
    end

    // Low 2W bits of the product of extended operands equal the signed/unsigned product
    always_comb begin
        w_ext_a = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
        w_ext_b = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
        w_prod  = w_ext_a * w_ext_b;
        w_neg_a = r_signed && r_a[WIDTH-1];
        w_neg_b = r_signed && r_b[WIDTH-1];
        w_mag_a = w_neg_a ? -r_a : r_a;
        w_mag_b = w_neg_b ? -r_b : r_b;
        w_q     = (w_mag_b == '0) ? '0 : w_mag_a / w_mag_b;
        w_r     = (w_mag_b == '0) ? '0 : w_mag_a % w_mag_b;
        w_quo   = (w_neg_a ^ w_neg_b) ? -w_q : w_q;
        w_rem   = w_neg_a ? -w_r : w_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_mul    <= 1'b0;
            r_signed <= 1'b0;
        end else if (Start) begin
            r_cnt    <= w_e_dec.is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
            r_a      <= A;
            r_b      <= B;
            r_mul    <= w_e_dec.is_mul;
            r_signed <= w_e_dec.is_signed;
        end else if (Busy && !w_done) begin
            r_cnt    <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            if (r_mul) begin
                {r_hi, r_lo} <= w_prod;
            end else if (r_b != '0) begin
                r_hi <= w_rem;
                r_lo <= w_quo;
            end
        end else if (E_Valid && !Busy) begin
            if (w_e_dec.is_mthi) r_hi <= A;
            if (w_e_dec.is_mtlo) r_lo <= A;
        end
    end
endmodule

// File: tb/tb_muldiv_controller.sv
// tb_muldiv_controller: randomized and directed checks against a cycle-level HI/LO reference model
module tb_muldiv_controller;
    localparam int W  = 32;
    localparam int NM = 5;
    localparam int ND = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    D_Opcode = 6'h3f, D_Funct = 6'h0, E_Opcode = 6'h3f, E_Funct = 6'h0;
    logic          E_Valid = 1'b0;
    logic [W-1:0]  A = '0, B = '0;
    logic          Start, Busy, StallReq, MDRead;
    logic [W-1:0]  MDOut, HI, LO;

    always #5 clk = ~clk;

    muldiv_controller #(.WIDTH(W), .MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_Opcode(D_Opcode), .D_Funct(D_Funct), .E_Opcode(E_Opcode), .E_Funct(E_Funct),
        .E_Valid(E_Valid), .A(A), .B(B),
        .Start(Start), .Busy(Busy), .StallReq(StallReq), .MDRead(MDRead),
        .MDOut(MDOut), .HI(HI), .LO(LO)
    );

    int          n_chk = 0, n_pass = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        p_wr = 1'b0;
    int          rem = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Architectural result of an arithmetic md op, computed with 64-bit integer arithmetic
    task automatic model_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub, pr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        p_wr = 1'b1;
        case (fn)
            6'h18: begin pr = longint'(sa * sb); {p_hi, p_lo} = pr; end
            6'h19: begin pr = ua * ub; {p_hi, p_lo} = pr; end
            6'h1A: if (b == 0) p_wr = 1'b0;
                   else begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
            default: if (b == 0) p_wr = 1'b0;
                     else begin p_lo = 32'(ua / ub); p_hi = 32'(ua % ub); end
        endcase
    endtask

    task automatic cyc(input logic [5:0] dop, input logic [5:0] dfn, input logic [5:0] eop,
                       input logic [5:0] efn, input logic ev, input logic [31:0] a, input logic [31:0] b);
        logic        busy_e, start_e, stall_e, rd_e, e_r;
        logic [31:0] out_e;
        D_Opcode = dop; D_Funct = dfn; E_Opcode = eop; E_Funct = efn; E_Valid = ev; A = a; B = b;
        e_r     = (eop == 6'h0);
        busy_e  = (rem > 0);
        start_e = ev && e_r && (efn inside {[6'h18:6'h1B]}) && !busy_e;
        stall_e = (start_e || busy_e) && dop == 6'h0 && (dfn inside {[6'h10:6'h13], [6'h18:6'h1B]});
        rd_e    = e_r && (efn == 6'h10 || efn == 6'h12);
        out_e   = !rd_e ? 32'h0 : (efn == 6'h10) ? m_hi : m_lo;
        @(negedge clk);
        check("busy", 32'(Busy), 32'(busy_e));
        check("start", 32'(Start), 32'(start_e));
        check("stallreq", 32'(StallReq), 32'(stall_e));
        check("mdread", 32'(MDRead), 32'(rd_e));
        check("mdout", MDOut, out_e);
        check("hi", HI, m_hi);
        check("lo", LO, m_lo);
        @(posedge clk);
        if (rem > 0) begin
            rem--;
            if (rem == 0 && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (start_e) begin
            rem = (efn inside {6'h18, 6'h19}) ? NM : ND;
            model_op(efn, a, b);
        end else if (ev && e_r && efn == 6'h11) m_hi = a;
        else if (ev && e_r && efn == 6'h13) m_lo = a;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(6'h3f, 6'h0, 6'h3f, 6'h0, 1'b0, '0, '0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] fns [12] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13,
                             6'h18, 6'h1A, 6'h20, 6'h21};

    initial begin
        #1;
        check("rst_busy", 32'(Busy), 32'h0);
        check("rst_hi", HI, 32'h0);
        check("rst_lo", LO, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(1);

        cyc(6'h3f, 6'h0, 6'h0, 6'h18, 1'b1, 32'd3, 32'hFFFF_FFFE);
        idle(NM);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFA);

        cyc(6'h3f, 6'h0, 6'h0, 6'h19, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(NM);
        check("multu_hi", HI, 32'hFFFF_FFFE);
        check("multu_lo", LO, 32'h0000_0001);

        cyc(6'h3f, 6'h0, 6'h0, 6'h1A, 1'b1, 32'hFFFF_FFF9, 32'd2);
        idle(ND);
        check("div_hi", HI, 32'hFFFF_FFFF);
        check("div_lo", LO, 32'hFFFF_FFFD);

        cyc(6'h3f, 6'h0, 6'h0, 6'h1A, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(ND);
        check("divovf_hi", HI, 32'h0);
        check("divovf_lo", LO, 32'h8000_0000);

        cyc(6'h3f, 6'h0, 6'h0, 6'h1B, 1'b1, 32'h1234_5678, 32'h0);
        idle(ND);
        check("divz_hi", HI, 32'h0);
        check("divz_lo", LO, 32'h8000_0000);

        cyc(6'h0, 6'h12, 6'h0, 6'h1A, 1'b1, 32'h100, 32'd7);
        for (int i = 0; i < ND; i++) cyc(6'h0, 6'h12, 6'h0, 6'h11, 1'b1, 32'hDEAD_BEEF, 32'h0);
        cyc(6'h0, 6'h12, 6'h3f, 6'h0, 1'b1, '0, '0);
        check("stalldiv_hi", HI, 32'd4);
        check("stalldiv_lo", LO, 32'd36);

        cyc(6'h3f, 6'h0, 6'h0, 6'h13, 1'b1, 32'h1234, 32'h0);
        check("mtlo_lo", LO, 32'h1234);
        cyc(6'h3f, 6'h0, 6'h0, 6'h12, 1'b1, 32'h0, 32'h0);
        cyc(6'h3f, 6'h0, 6'h0, 6'h11, 1'b1, 32'h5555, 32'h0);
        cyc(6'h3f, 6'h0, 6'h0, 6'h10, 1'b1, 32'h0, 32'h0);

        cyc(6'h3f, 6'h0, 6'h0, 6'h18, 1'b1, 32'h7, 32'h9);
        idle(2);
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", 32'(Busy), 32'h0);
        check("rstmid_hi", HI, 32'h0);
        check("rstmid_lo", LO, 32'h0);
        rem = 0; m_hi = '0; m_lo = '0; p_wr = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) == 0) ? 6'h08 : 6'h0, fns[$urandom_range(0, 11)],
                ($urandom_range(0, 7) == 0) ? 6'h08 : 6'h0, fns[$urandom_range(0, 11)],
                ($urandom_range(0, 3) != 0), rnd_val(), rnd_val());
        end
        idle(ND + 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
